// File: rtl/bcd_display_driver_pkg.sv
// Shared seven-segment code constants (active-low, bit order g f e d c b a)
// for the display blocks.
package bcd_display_driver_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_code_t;

    localparam seg_code_t SEG_0     = 7'h40;
    localparam seg_code_t SEG_1     = 7'h79;
    localparam seg_code_t SEG_2     = 7'h24;
    localparam seg_code_t SEG_3     = 7'h30;
    localparam seg_code_t SEG_4     = 7'h19;
    localparam seg_code_t SEG_5     = 7'h12;
    localparam seg_code_t SEG_6     = 7'h02;
    localparam seg_code_t SEG_7     = 7'h78;
    localparam seg_code_t SEG_8     = 7'h00;
    localparam seg_code_t SEG_9     = 7'h10;
    localparam seg_code_t SEG_DASH  = 7'h3F;
    localparam seg_code_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_seven_seg.sv
// Combinational BCD-to-seven-segment decoder with a blank override.
// Values 10-15 render as a lone g segment to flag invalid BCD.
module bcd_seven_seg
    import bcd_display_driver_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Multi-digit BCD display driver: load-captured value, leading-zero
// suppression and blink, with registered active-low segment outputs.
module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DIGITS*4-1:0]   bcd,
    input  logic                  load,
    input  logic                  blank_zeros,
    input  logic                  blink,
    output logic [DIGITS*7-1:0]   seg
);

    localparam int               CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [DIGITS*4-1:0] hold;
    logic [CNT_W-1:0]    prescale;
    logic                phase;
    logic [DIGITS-1:0]   lz_blank;
    logic                zero_above;
    logic                blink_off;
    logic [DIGITS*7-1:0] seg_next;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold <= '0;
        end else if (load) begin
            hold <= bcd;
        end
    end

    // A load restarts the blink cycle so a fresh value is shown at once.
    always_ff @(posedge clock) begin
        if (reset || load || !blink) begin
            prescale <= '0;
            phase    <= 1'b0;
        end else if (prescale == CNT_LAST) begin
            prescale <= '0;
            phase    <= ~phase;
        end else begin
            prescale <= prescale + CNT_W'(1);
        end
    end

    // Scan from the top digit down; digit 0 is never suppressed.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above && (hold[i*4 +: 4] == 4'd0);
            lz_blank[i] = blank_zeros && zero_above;
        end
    end

    assign blink_off = blink && phase;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_seven_seg u_dec (
            .digit (hold[i*4 +: 4]),
            .blank (lz_blank[i] || blink_off),
            .seg   (seg_next[i*7 +: 7])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg <= '1;
        end else begin
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver (DIGITS=3, BLINK_DIV=4) with an
// expected-value queue popped after each clock edge.
module tb_bcd_display_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] bcd;
    logic        load;
    logic        blank_zeros;
    logic        blink;
    logic [20:0] seg;

    logic [20:0] exp_q[$];
    string       tag_q[$];
    int          passes = 0;
    int          total  = 0;

    localparam logic [20:0] ALL_OFF = 21'h1FFFFF;

    bcd_display_driver #(.DIGITS(3), .BLINK_DIV(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .bcd         (bcd),
        .load        (load),
        .blank_zeros (blank_zeros),
        .blink       (blink),
        .seg         (seg)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", passes, total);
        $fatal(1);
    end

    function automatic logic [20:0] segs3(input logic [6:0] d2, input logic [6:0] d1,
                                          input logic [6:0] d0);
        return {d2, d1, d0};
    endfunction

    task automatic check();
        logic [20:0] exp;
        string       tag;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: seg=%h with no expected value", seg);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (seg === exp) passes++;
            else $error("FAIL %s: seg=%h expected=%h", tag, seg, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock it, sample 1 ns later.
    task automatic edge_expect(input string tag, input logic [20:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        check();
    endtask

    initial begin
        logic [20:0] v042, v321, v905;
        v042 = segs3(7'h40, 7'h19, 7'h24);
        v321 = segs3(7'h30, 7'h24, 7'h79);
        v905 = segs3(7'h10, 7'h40, 7'h12);

        // Reset with a competing load
        reset = 1'b1; load = 1'b1; bcd = 12'h123; blank_zeros = 1'b0; blink = 1'b0;
        edge_expect("reset_1", ALL_OFF);
        edge_expect("reset_2", ALL_OFF);
        reset = 1'b0; load = 1'b0;
        edge_expect("post_reset_1", segs3(7'h40, 7'h40, 7'h40));
        edge_expect("post_reset_2", segs3(7'h40, 7'h40, 7'h40));

        // Load latency and retention
        bcd = 12'h905; load = 1'b1;
        edge_expect("load_edge_old", segs3(7'h40, 7'h40, 7'h40));
        load = 1'b0; bcd = 12'h777;
        edge_expect("load_905", v905);
        edge_expect("retain_905", v905);

        // Leading-zero suppression
        bcd = 12'h007; load = 1'b1;
        edge_expect("load_007_edge", v905);
        load = 1'b0; blank_zeros = 1'b1;
        edge_expect("blank_007", segs3(7'h7F, 7'h7F, 7'h78));
        blank_zeros = 1'b0;
        edge_expect("noblank_007", segs3(7'h40, 7'h40, 7'h78));
        blank_zeros = 1'b1; bcd = 12'h000; load = 1'b1;
        edge_expect("load_000_edge", segs3(7'h7F, 7'h7F, 7'h78));
        load = 1'b0;
        edge_expect("blank_000", segs3(7'h7F, 7'h7F, 7'h40));
        bcd = 12'h0A0; load = 1'b1;
        edge_expect("load_0a0_edge", segs3(7'h7F, 7'h7F, 7'h40));
        load = 1'b0;
        edge_expect("blank_0a0", segs3(7'h7F, 7'h3F, 7'h40));
        bcd = 12'h100; load = 1'b1;
        edge_expect("load_100_edge", segs3(7'h7F, 7'h3F, 7'h40));
        load = 1'b0;
        edge_expect("blank_100", segs3(7'h79, 7'h40, 7'h40));

        // Blink: 4 visible, 4 dark, repeating
        blank_zeros = 1'b0; bcd = 12'h042; load = 1'b1;
        edge_expect("load_042_edge", segs3(7'h79, 7'h40, 7'h40));
        load = 1'b0;
        edge_expect("show_042", v042);
        blink = 1'b1;
        for (int k = 0; k < 12; k++) begin
            edge_expect($sformatf("blink_cyc%0d", k), ((k / 4) % 2 == 1) ? ALL_OFF : v042);
        end
        blink = 1'b0;
        edge_expect("blink_off_now", v042);

        // Load during the dark phase restarts a full visible phase
        blink = 1'b1;
        for (int k = 0; k < 5; k++) begin
            edge_expect($sformatf("reblink_cyc%0d", k), (k == 4) ? ALL_OFF : v042);
        end
        bcd = 12'h321; load = 1'b1;
        edge_expect("load_dark_edge", ALL_OFF);
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            edge_expect($sformatf("load_dark_vis%0d", k), v321);
        end
        edge_expect("load_dark_off", ALL_OFF);

        // Load and blink rising on the same edge
        blink = 1'b0;
        edge_expect("blink_drop", v321);
        blink = 1'b1; load = 1'b1; bcd = 12'h905;
        edge_expect("same_edge_old", v321);
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            edge_expect($sformatf("same_edge_vis%0d", k), v905);
        end
        edge_expect("same_edge_off", ALL_OFF);

        // Mid-run reset clears everything
        reset = 1'b1; load = 1'b1; bcd = 12'h888;
        edge_expect("reset_mid", ALL_OFF);
        reset = 1'b0; load = 1'b0;
        edge_expect("post_reset_mid", segs3(7'h40, 7'h40, 7'h40));
        edge_expect("post_reset_blink", segs3(7'h40, 7'h40, 7'h40));

        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
